// File: rtl/svcs_tx_arbiter_if.sv
// Channel bundle for svcs_tx_arbiter: requester headers, requester payload
// streams and the single outbound socket word stream.
// slave  = arbiter side, master = requesters plus the SV socket driver.
interface svcs_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int TYPE_W = 3
);
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][TYPE_W-1:0] req_type;
  logic [N_REQ-1:0][LEN_W-1:0]  req_size;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             dat_valid;
  logic [N_REQ-1:0][DATA_W-1:0] dat_data;
  logic [N_REQ-1:0]             dat_ready;
  logic                         out_valid;
  logic [DATA_W-1:0]            out_data;
  logic                         out_sof;
  logic                         out_ready;

  modport slave (
    input  req_valid, req_type, req_size, dat_valid, dat_data, out_ready,
    output req_ready, dat_ready, out_valid, out_data, out_sof
  );
  modport master (
    output req_valid, req_type, req_size, dat_valid, dat_data, out_ready,
    input  req_ready, dat_ready, out_valid, out_data, out_sof
  );
endinterface

// File: rtl/svcs_tx_arbiter.sv
// svcs_tx_arbiter: round-robin framer that shares one outbound SVCS socket
// channel between N_REQ requesters. Each grant emits a header word
// {type,id,size} followed by exactly SIZE payload words, never interleaved.
// Optional feature macro: SVCS_ARB_TIMEOUT_EN (payload stall timeout that
// pads the message with zero words and raises a sticky err_timeout).
module svcs_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 8,
  parameter int TYPE_W      = 3,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  svcs_tx_arbiter_if.slave bus,
  output logic             busy,
  output logic             err_timeout
);
  localparam int ID_W = $clog2(N_REQ);

`ifdef SVCS_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, HDR, PAY, PAD} state_t;
  localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
  logic [ST_W-1:0] stall_q, stall_d;
  logic            err_q, err_d;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;     // highest-priority requester for next grant
  logic [ID_W-1:0]   gnt_q, gnt_d;   // id of the requester owning the channel
  logic [TYPE_W-1:0] type_q, type_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;   // holds size in HDR, words left in PAY/PAD
  logic              found;
  logic [ID_W-1:0]   win, idx;

  // Round-robin search starting at rr_q; first pending requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(rr_q) + 32'(k)) % N_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and channel outputs.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    gnt_d         = gnt_q;
    type_d        = type_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;
    bus.dat_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_sof   = 1'b0;
    bus.out_data  = '0;
`ifdef SVCS_ARB_TIMEOUT_EN
    stall_d = '0;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          bus.req_ready[win] = 1'b1;
          gnt_d   = win;
          type_d  = bus.req_type[win];
          cnt_d   = bus.req_size[win];
          rr_d    = ID_W'((32'(win) + 32'd1) % N_REQ);
          state_d = HDR;
        end
      end
      HDR: begin
        bus.out_valid = 1'b1;
        bus.out_sof   = 1'b1;
        bus.out_data  = DATA_W'({type_q, gnt_q, cnt_q});
        if (bus.out_ready) state_d = (cnt_q == '0) ? IDLE : PAY;
      end
      PAY: begin
        bus.out_valid        = bus.dat_valid[gnt_q];
        bus.out_data         = bus.dat_data[gnt_q];
        bus.dat_ready[gnt_q] = bus.out_ready;
        if (bus.dat_valid[gnt_q] && bus.out_ready) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = IDLE;
        end
`ifdef SVCS_ARB_TIMEOUT_EN
        else if (bus.out_ready) begin
          // Requester starved the channel; counting only while the driver is ready.
          if (stall_q == ST_W'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = PAD;
          end else begin
            stall_d = stall_q + ST_W'(1);
          end
        end else begin
          stall_d = stall_q;
        end
`endif
      end
`ifdef SVCS_ARB_TIMEOUT_EN
      PAD: begin
        // Fill the rest of the message with zeros so the driver stays in frame.
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset abandons any partial message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      type_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SVCS_ARB_TIMEOUT_EN
  // Stall counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_svcs_tx_arbiter.sv
// Scoreboard bench for svcs_tx_arbiter: directed transactions push their
// hand-computed channel words; a monitor pops and compares every accepted
// word and checks that stalled words are held stable.
module tb_svcs_tx_arbiter;
  localparam int N = 4, DW = 32, LW = 8, TW = 3;

  typedef struct packed { logic [TW-1:0] typ; logic [LW-1:0] size; } txn_t;
  typedef logic [DW-1:0] wq_t[$];
  typedef txn_t tq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err_timeout;
  logic ortog = 1'b0;
  int   nvec = 0, nerr = 0;

  tq_t  txn_q [N];
  wq_t  pay_src [N];
  wq_t  act [N];
  logic [DW:0] sb[$];

  svcs_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW), .TYPE_W(TW)) bus ();

  svcs_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW), .TYPE_W(TW), .TIMEOUT_CYC(256)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Requester and socket-driver model: hold words until handshaked.
  initial begin
    logic       rs;
    logic [N-1:0] rh, dh;
    txn_t       t;
    bus.req_valid = '0; bus.req_type = '0; bus.req_size = '0;
    bus.dat_valid = '0; bus.dat_data = '0; bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      rs = rst;
      rh = rst ? '0 : (bus.req_valid & bus.req_ready);
      dh = rst ? '0 : (bus.dat_valid & bus.dat_ready);
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (rs) act[i].delete();
        if (rh[i]) begin
          t = txn_q[i].pop_front();
          for (int k = 0; k < int'(t.size) && pay_src[i].size() != 0; k++)
            act[i].push_back(pay_src[i].pop_front());
        end
        if (dh[i]) void'(act[i].pop_front());
        bus.req_valid[i] = (txn_q[i].size() != 0);
        bus.req_type[i]  = (txn_q[i].size() != 0) ? txn_q[i][0].typ  : '0;
        bus.req_size[i]  = (txn_q[i].size() != 0) ? txn_q[i][0].size : '0;
        bus.dat_valid[i] = (act[i].size() != 0);
        bus.dat_data[i]  = (act[i].size() != 0) ? act[i][0] : '0;
      end
      bus.out_ready = ortog ? ~bus.out_ready : 1'b1;
    end
  end

  // Monitor: compare every accepted word; stalled words must not change.
  initial begin
    logic          pv, ps;
    logic [DW-1:0] pd;
    logic [DW:0]   e;
    pv = 1'b0; ps = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          nvec++;
          if (!(bus.out_valid && bus.out_data == pd && bus.out_sof == ps)) begin
            nerr++;
            $display("FAIL hold: got v=%0b sof=%0b %08h want v=1 sof=%0b %08h",
                     bus.out_valid, bus.out_sof, bus.out_data, ps, pd);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          nvec++;
          if (sb.size() == 0) begin
            nerr++;
            $display("FAIL word: got unexpected sof=%0b %08h want none", bus.out_sof, bus.out_data);
          end else begin
            e = sb.pop_front();
            if ({bus.out_sof, bus.out_data} !== e) begin
              nerr++;
              $display("FAIL word: got sof=%0b %08h want sof=%0b %08h",
                       bus.out_sof, bus.out_data, e[DW], e[DW-1:0]);
            end
          end
        end
        pv = bus.out_valid && !bus.out_ready;
        ps = bus.out_sof;
        pd = bus.out_data;
      end
    end
  end

  task automatic issue(input int r, input logic [TW-1:0] t, input logic [LW-1:0] s);
    txn_t x;
    x.typ = t; x.size = s;
    txn_q[r].push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic drain(input string nm, input int maxc);
    int c;
    c = 0;
    while (sb.size() != 0 && c < maxc) begin
      @(posedge clk); #1; c++;
    end
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL %s drain: got %0d words outstanding want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic rst_check(input string nm);
    @(negedge clk);
    chk({nm, " out_valid"}, 32'(bus.out_valid), 0);
    chk({nm, " out_sof"},   32'(bus.out_sof), 0);
    chk({nm, " out_data"},  bus.out_data, 0);
    chk({nm, " busy"},      32'(busy), 0);
    chk({nm, " req_ready"}, 32'(bus.req_ready), 0);
    chk({nm, " dat_ready"}, 32'(bus.dat_ready), 0);
    chk({nm, " err"},       32'(err_timeout), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rst_check("reset");

    // 1: single transaction from requester 2, type 1, size 3.
    @(posedge clk); #1;
    issue(2, 3'd1, 8'd3);
    pay_src[2].push_back(32'hAAAA_0001);
    pay_src[2].push_back(32'hBBBB_0002);
    pay_src[2].push_back(32'hCCCC_0003);
    sb.push_back({1'b1, 32'h0000_0603});
    sb.push_back({1'b0, 32'hAAAA_0001});
    sb.push_back({1'b0, 32'hBBBB_0002});
    sb.push_back({1'b0, 32'hCCCC_0003});
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1 busy mid", 32'(busy), 1);
    drain("t1", 100);
    @(negedge clk);
    chk("t1 busy after", 32'(busy), 0);

    // 2: all four request together, size 1 each; grant order 0,1,2,3,0.
    do_reset();
    issue(0, 3'd0, 8'd1); pay_src[0].push_back(32'hD000_0000);
    issue(0, 3'd0, 8'd1); pay_src[0].push_back(32'hD000_0001);
    issue(1, 3'd0, 8'd1); pay_src[1].push_back(32'hD100_0000);
    issue(2, 3'd0, 8'd1); pay_src[2].push_back(32'hD200_0000);
    issue(3, 3'd0, 8'd1); pay_src[3].push_back(32'hD300_0000);
    sb.push_back({1'b1, 32'h0000_0001}); sb.push_back({1'b0, 32'hD000_0000});
    sb.push_back({1'b1, 32'h0000_0101}); sb.push_back({1'b0, 32'hD100_0000});
    sb.push_back({1'b1, 32'h0000_0201}); sb.push_back({1'b0, 32'hD200_0000});
    sb.push_back({1'b1, 32'h0000_0301}); sb.push_back({1'b0, 32'hD300_0000});
    sb.push_back({1'b1, 32'h0000_0001}); sb.push_back({1'b0, 32'hD000_0001});
    drain("t2", 200);

    // 3: zero-size message from requester 1, type 5: header only.
    @(posedge clk); #1;
    issue(1, 3'd5, 8'd0);
    sb.push_back({1'b1, 32'h0000_1500});
    drain("t3", 100);
    @(negedge clk);
    chk("t3 busy after", 32'(busy), 0);

    // 4: requester 3, type 3, size 4 with out_ready toggling.
    @(posedge clk); #1;
    ortog = 1'b1;
    issue(3, 3'd3, 8'd4);
    for (int k = 0; k < 4; k++) pay_src[3].push_back(32'hE300_0000 + 32'(k));
    sb.push_back({1'b1, 32'h0000_0F04});
    for (int k = 0; k < 4; k++) sb.push_back({1'b0, 32'hE300_0000 + 32'(k)});
    drain("t4", 200);
    ortog = 1'b0;
    repeat (3) @(posedge clk);

    // 5: reset after 2 of 5 payload words, then rr pointer must restart at 0.
    #1;
    issue(1, 3'd4, 8'd5);
    for (int k = 0; k < 5; k++) pay_src[1].push_back(32'hF100_0000 + 32'(k));
    sb.push_back({1'b1, 32'h0000_1105});
    sb.push_back({1'b0, 32'hF100_0000});
    sb.push_back({1'b0, 32'hF100_0001});
    drain("t5a", 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pay_src[1].delete();
    rst_check("t5 reset");
    @(posedge clk); #1;
    issue(3, 3'd2, 8'd1); pay_src[3].push_back(32'h5300_0000);
    issue(0, 3'd2, 8'd1); pay_src[0].push_back(32'h5000_0000);
    sb.push_back({1'b1, 32'h0000_0801}); sb.push_back({1'b0, 32'h5000_0000});
    sb.push_back({1'b1, 32'h0000_0B01}); sb.push_back({1'b0, 32'h5300_0000});
    drain("t5b", 100);

`ifdef SVCS_ARB_TIMEOUT_EN
    // 6: only one of three payload words ever arrives; expect padding.
    @(posedge clk); #1;
    issue(0, 3'd1, 8'd3);
    pay_src[0].push_back(32'h6000_0001);
    sb.push_back({1'b1, 32'h0000_0403});
    sb.push_back({1'b0, 32'h6000_0001});
    sb.push_back({1'b0, 32'h0000_0000});
    sb.push_back({1'b0, 32'h0000_0000});
    drain("t6", 600);
    @(negedge clk);
    chk("t6 err", 32'(err_timeout), 1);
    chk("t6 busy", 32'(busy), 0);
`else
    @(negedge clk);
    chk("err tied low", 32'(err_timeout), 0);
`endif

    repeat (4) @(posedge clk);
    chk("sb empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
